// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// The helper functions classify an operation as divide and/or signed.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    MD_Mult  = 2'b00,
    MD_Multu = 2'b01,
    MD_Div   = 2'b10,
    MD_Divu  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } md_state_e;

  function automatic logic op_is_div(input md_op_e op);
    case (op)
      MD_Div, MD_Divu: op_is_div = 1'b1;
      default:         op_is_div = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_signed(input md_op_e op);
    case (op)
      MD_Mult, MD_Div: op_is_signed = 1'b1;
      default:         op_is_signed = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply, shift/trial-subtract/restore for divide.
// For divide, the low bit of next_partial is left clear and the quotient bit is returned separately.
module muldiv_step
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] partial,
  input  logic [WIDTH-1:0] operand,
  input  md_op_e           op,
  output logic [2*WIDTH:0] next_partial,
  output logic             qbit
);

  logic [2*WIDTH:0] shifted_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH:0]   sum_s;

  // Upper WIDTH+1 bits hold the running high half (multiply) or remainder (divide).
  always_comb begin
    shifted_s    = {partial[2*WIDTH-1:0], 1'b0};
    trial_s      = shifted_s[2*WIDTH:WIDTH] - {1'b0, operand};
    sum_s        = partial[2*WIDTH:WIDTH];
    next_partial = partial;
    qbit         = 1'b0;
    if (op_is_div(op)) begin
      if (trial_s[WIDTH]) begin
        next_partial = shifted_s;
        qbit         = 1'b0;
      end else begin
        next_partial = {trial_s, shifted_s[WIDTH-1:0]};
        qbit         = 1'b1;
      end
    end else begin
      if (partial[0]) begin
        sum_s = partial[2*WIDTH:WIDTH] + {1'b0, operand};
      end else begin
        sum_s = partial[2*WIDTH:WIDTH];
      end
      next_partial = {1'b0, sum_s, partial[WIDTH-1:1]};
      qbit         = 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO: magnitudes are iterated for WIDTH cycles,
// then a FIX cycle applies sign correction and writes the result registers.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             WrHi,
  input  logic             WrLo,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  md_state_e        state_r, state_next_s;
  md_op_e           op_r, op_in_s;
  logic [CW-1:0]    count_r;
  logic [2*WIDTH:0] partial_r, step_next_s;
  logic [WIDTH-1:0] operand_r, araw_r, hi_r, lo_r;
  logic [WIDTH-1:0] a_abs_s, b_abs_s, fix_hi_s, fix_lo_s;
  logic [2*WIDTH-1:0] prod_s;
  logic             neg_lo_r, neg_hi_r, done_r, dbz_r;
  logic             qbit_s, fix_dbz_s, start_div_s, start_signed_s;

  assign op_in_s        = md_op_e'(Op);
  assign start_div_s    = op_is_div(op_in_s);
  assign start_signed_s = op_is_signed(op_in_s);
  assign a_abs_s        = (start_signed_s && A[WIDTH-1]) ? -A : A;
  assign b_abs_s        = (start_signed_s && B[WIDTH-1]) ? -B : B;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .partial      (partial_r),
    .operand      (operand_r),
    .op           (op_r),
    .next_partial (step_next_s),
    .qbit         (qbit_s)
  );

  // Next-state logic; Start is only honoured in IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (Start) state_next_s = CALC;
        else       state_next_s = IDLE;
      end
      CALC: begin
        if (count_r == {CW{1'b0}}) state_next_s = FIX;
        else                       state_next_s = CALC;
      end
      FIX:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Sign correction of the magnitude result; divide by zero overrides the datapath.
  always_comb begin
    if (neg_lo_r) prod_s = -partial_r[2*WIDTH-1:0];
    else          prod_s = partial_r[2*WIDTH-1:0];
    fix_hi_s  = prod_s[2*WIDTH-1:WIDTH];
    fix_lo_s  = prod_s[WIDTH-1:0];
    fix_dbz_s = 1'b0;
    if (op_is_div(op_r)) begin
      if (operand_r == {WIDTH{1'b0}}) begin
        fix_hi_s  = araw_r;
        fix_lo_s  = {WIDTH{1'b1}};
        fix_dbz_s = 1'b1;
      end else begin
        fix_lo_s  = neg_lo_r ? -partial_r[WIDTH-1:0] : partial_r[WIDTH-1:0];
        fix_hi_s  = neg_hi_r ? -partial_r[2*WIDTH-1:WIDTH] : partial_r[2*WIDTH-1:WIDTH];
        fix_dbz_s = 1'b0;
      end
    end else begin
      fix_dbz_s = 1'b0;
    end
  end

  // State, operand and HI/LO registers; Reset overrides every other update.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r   <= IDLE;
      op_r      <= MD_Mult;
      count_r   <= {CW{1'b0}};
      partial_r <= {(2*WIDTH+1){1'b0}};
      operand_r <= {WIDTH{1'b0}};
      araw_r    <= {WIDTH{1'b0}};
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      neg_lo_r  <= 1'b0;
      neg_hi_r  <= 1'b0;
      done_r    <= 1'b0;
      dbz_r     <= 1'b0;
    end else begin
      state_r <= state_next_s;
      done_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (Start) begin
            op_r      <= op_in_s;
            count_r   <= CW'(WIDTH - 1);
            partial_r <= {{(WIDTH+1){1'b0}}, (start_div_s ? a_abs_s : b_abs_s)};
            operand_r <= start_div_s ? b_abs_s : a_abs_s;
            araw_r    <= A;
            neg_lo_r  <= start_signed_s & (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_hi_r  <= start_signed_s & start_div_s & A[WIDTH-1];
            dbz_r     <= 1'b0;
          end else begin
            if (WrHi) hi_r <= A;
            if (WrLo) lo_r <= A;
          end
        end
        CALC: begin
          partial_r <= {step_next_s[2*WIDTH:1], step_next_s[0] | qbit_s};
          if (count_r != {CW{1'b0}}) count_r <= count_r - CW'(1);
        end
        FIX: begin
          hi_r   <= fix_hi_s;
          lo_r   <= fix_lo_s;
          dbz_r  <= fix_dbz_s;
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Hi        = hi_r;
  assign Lo        = lo_r;
  assign Busy      = (state_r != IDLE);
  assign Done      = done_r;
  assign DivByZero = dbz_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, protocol scenarios and
// randomized operations compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic          Clock = 1'b0;
  logic          Reset, Start, WrHi, WrLo;
  logic [1:0]    Op;
  logic [W-1:0]  A, B, Hi, Lo;
  logic          Busy, Done, DivByZero;

  int checks   = 0;
  int failures = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .WrHi(WrHi), .WrLo(WrLo), .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done),
    .DivByZero(DivByZero)
  );

  always #5 Clock = ~Clock;

  function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    longint sa, sb, p;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dbz = 1'b0;
    hi = 32'h0;
    lo = 32'h0;
    case (op)
      2'b00: begin p = sa * sb; {hi, lo} = p; end
      2'b01: begin up = {32'h0, a} * {32'h0, b}; {hi, lo} = up; end
      2'b10: begin
        if (b == 32'h0) begin hi = a; lo = 32'hFFFFFFFF; dbz = 1'b1; end
        else begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
      end
      default: begin
        if (b == 32'h0) begin hi = a; lo = 32'hFFFFFFFF; dbz = 1'b1; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endfunction

  // Pulse Start for one edge, then follow the op up to just after the result edge.
  task automatic launch_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int busy_cycles, output bit hold_ok);
    logic [31:0] hi0, lo0;
    @(negedge Clock);
    Start = 1'b1; Op = op; A = a; B = b;
    hi0 = Hi; lo0 = Lo;
    @(posedge Clock); #1;
    Start = 1'b0; A = 32'h0; B = 32'h0;
    busy_cycles = 0;
    hold_ok = 1'b1;
    for (int i = 0; i < W + 1; i++) begin
      if (Busy) busy_cycles++;
      if (Hi !== hi0 || Lo !== lo0 || Done !== 1'b0) hold_ok = 1'b0;
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b1; WrHi = 1'b1; WrLo = 1'b1; Op = 2'b11; A = 32'h55; B = 32'h3;
    repeat (2) @(posedge Clock);
    #1;
    checks++;
    if (Hi !== 32'h0 || Lo !== 32'h0 || Busy !== 1'b0 || Done !== 1'b0 || DivByZero !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got hi=%h lo=%h busy=%b done=%b dbz=%b exp all zero",
               Hi, Lo, Busy, Done, DivByZero);
    end
    @(negedge Clock);
    Reset = 1'b0; Start = 1'b0; WrHi = 1'b0; WrLo = 1'b0; A = 32'h0; B = 32'h0;
  endtask

  task automatic test_directed();
    logic [1:0]  t_op  [10] = '{2'b11, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 2'b11, 2'b10, 2'b00, 2'b10};
    logic [31:0] t_a   [10] = '{32'd11, 32'hFFFFFFF9, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'hFFFFFFFF, 32'd5, 32'd7, 32'hFFFFFFFE, 32'h0};
    logic [31:0] t_b   [10] = '{32'd3, 32'd2, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF,
                                32'd0, 32'd0, 32'hFFFFFFFE, 32'd3, 32'h0};
    logic [31:0] t_hi  [10] = '{32'd2, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE,
                                32'h0, 32'd5, 32'd1, 32'hFFFFFFFF, 32'h0};
    logic [31:0] t_lo  [10] = '{32'd3, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'h00000001,
                                32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFA, 32'hFFFFFFFF};
    logic        t_dbz [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int bc;
    bit hold;
    for (int k = 0; k < 10; k++) begin
      launch_op(t_op[k], t_a[k], t_b[k], bc, hold);
      checks++;
      if (bc !== W + 1 || !hold) begin
        failures++;
        $display("FAIL dir%0d_timing busy_cycles=%0d hold=%0b exp busy_cycles=%0d hold=1", k, bc, hold, W + 1);
      end
      checks++;
      if (Done !== 1'b1 || Busy !== 1'b0 || Hi !== t_hi[k] || Lo !== t_lo[k] || DivByZero !== t_dbz[k]) begin
        failures++;
        $display("FAIL dir%0d_result got done=%b busy=%b hi=%h lo=%h dbz=%b exp done=1 busy=0 hi=%h lo=%h dbz=%b",
                 k, Done, Busy, Hi, Lo, DivByZero, t_hi[k], t_lo[k], t_dbz[k]);
      end
      @(posedge Clock); #1;
      checks++;
      if (Done !== 1'b0) begin
        failures++;
        $display("FAIL dir%0d_done_pulse got done=%b exp 0", k, Done);
      end
    end
  endtask

  task automatic test_divzero_clear();
    int bc;
    bit hold;
    launch_op(2'b11, 32'd5, 32'd0, bc, hold);
    @(negedge Clock);
    Start = 1'b1; Op = 2'b11; A = 32'd7; B = 32'd7;
    @(posedge Clock); #1;
    Start = 1'b0;
    checks++;
    if (DivByZero !== 1'b0) begin
      failures++;
      $display("FAIL dbz_clear_on_start got=%b exp=0", DivByZero);
    end
    repeat (W + 1) @(posedge Clock);
    #1;
    checks++;
    if (Hi !== 32'd0 || Lo !== 32'd1 || DivByZero !== 1'b0 || Done !== 1'b1) begin
      failures++;
      $display("FAIL dbz_followup got hi=%h lo=%h dbz=%b done=%b exp hi=0 lo=1 dbz=0 done=1", Hi, Lo, DivByZero, Done);
    end
  endtask

  task automatic test_reset_mid();
    int bc, seen;
    bit hold;
    @(negedge Clock);
    WrHi = 1'b1; WrLo = 1'b1; A = 32'hFFFF;
    @(negedge Clock);
    WrHi = 1'b0; WrLo = 1'b0;
    Start = 1'b1; Op = 2'b10; A = 32'd10; B = 32'd3;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (9) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock); #1;
    checks++;
    if (Hi !== 32'h0 || Lo !== 32'h0 || Busy !== 1'b0 || Done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got hi=%h lo=%h busy=%b done=%b exp all zero", Hi, Lo, Busy, Done);
    end
    @(negedge Clock);
    Reset = 1'b0;
    seen = 0;
    for (int i = 0; i < W + 8; i++) begin
      @(posedge Clock); #1;
      if (Done !== 1'b0 || Busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_mid_no_done got=%0d active cycles exp=0", seen);
    end
    launch_op(2'b10, 32'd11, 32'd3, bc, hold);
    checks++;
    if (Hi !== 32'd2 || Lo !== 32'd3 || Done !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_next_op got hi=%h lo=%h done=%b exp hi=2 lo=3 done=1", Hi, Lo, Done);
    end
  endtask

  task automatic test_busy_ignore();
    int extra;
    @(negedge Clock);
    Start = 1'b1; Op = 2'b11; A = 32'd100; B = 32'd7;
    @(posedge Clock); #1;
    Start = 1'b0;
    for (int i = 1; i <= W + 1; i++) begin
      @(negedge Clock);
      if (i == 5) begin Start = 1'b1; Op = 2'b01; A = 32'd9; B = 32'd2; end
      if (i == 8) begin WrHi = 1'b1; A = 32'h1234; end
      @(posedge Clock); #1;
      Start = 1'b0; WrHi = 1'b0;
    end
    checks++;
    if (Done !== 1'b1 || Hi !== 32'd2 || Lo !== 32'd14) begin
      failures++;
      $display("FAIL busy_ignore got done=%b hi=%h lo=%h exp done=1 hi=2 lo=e", Done, Hi, Lo);
    end
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #1;
      if (Busy !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL busy_no_queue got=%0d busy cycles exp=0", extra);
    end
  endtask

  task automatic test_writes();
    @(negedge Clock);
    WrHi = 1'b1; WrLo = 1'b1; A = 32'hABCD;
    @(posedge Clock); #1;
    WrHi = 1'b0; WrLo = 1'b0;
    checks++;
    if (Hi !== 32'hABCD || Lo !== 32'hABCD) begin
      failures++;
      $display("FAIL wr_both got hi=%h lo=%h exp abcd/abcd", Hi, Lo);
    end
    @(negedge Clock);
    WrHi = 1'b1; A = 32'h1111;
    @(posedge Clock); #1;
    WrHi = 1'b0;
    checks++;
    if (Hi !== 32'h1111 || Lo !== 32'hABCD) begin
      failures++;
      $display("FAIL wr_hi_only got hi=%h lo=%h exp 1111/abcd", Hi, Lo);
    end
    @(negedge Clock);
    Start = 1'b1; WrLo = 1'b1; Op = 2'b01; A = 32'd3; B = 32'd4;
    @(posedge Clock); #1;
    Start = 1'b0; WrLo = 1'b0;
    checks++;
    if (Lo !== 32'hABCD || Busy !== 1'b1) begin
      failures++;
      $display("FAIL start_wins got lo=%h busy=%b exp lo=abcd busy=1", Lo, Busy);
    end
    repeat (W + 1) @(posedge Clock);
    #1;
    checks++;
    if (Lo !== 32'd12 || Hi !== 32'd0 || Done !== 1'b1) begin
      failures++;
      $display("FAIL start_wins_result got hi=%h lo=%h done=%b exp hi=0 lo=c done=1", Hi, Lo, Done);
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b, ehi, elo;
    logic        edbz;
    int bc;
    bit hold;
    for (int k = 0; k < 24; k++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      case ($urandom_range(0, 5))
        0:       b = 32'h0;
        1:       b = 32'($urandom_range(1, 16));
        2:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      ref_model(op, a, b, ehi, elo, edbz);
      launch_op(op, a, b, bc, hold);
      checks++;
      if (bc !== W + 1 || !hold || Done !== 1'b1 || Hi !== ehi || Lo !== elo || DivByZero !== edbz) begin
        failures++;
        $display("FAIL rand%0d op=%0d a=%h b=%h got hi=%h lo=%h dbz=%b done=%b busy=%0d hold=%0b exp hi=%h lo=%h dbz=%b done=1 busy=%0d hold=1",
                 k, op, a, b, Hi, Lo, DivByZero, Done, bc, hold, ehi, elo, edbz, W + 1);
      end
    end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; WrHi = 1'b0; WrLo = 1'b0; Op = 2'b00; A = 32'h0; B = 32'h0;
    test_reset();
    test_directed();
    test_divzero_clear();
    test_reset_mid();
    test_busy_ignore();
    test_writes();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
